// File: rtl/evaluator_pkg.sv
// Shared types and constants for the sqrt(a^2 + b^2) evaluator.
package evaluator_pkg;

    localparam int unsigned MUL_ITERS  = 8;
    localparam int unsigned SQRT_ITERS = 9;
    localparam int unsigned OP_W       = 8;
    localparam int unsigned RAD_W      = 18;

    typedef enum logic [2:0] {
        IDLE,
        MUL_A,
        MUL_B,
        SUM,
        SQRT
    } state_e;

endpackage

// File: rtl/evaluator_mul.sv
// Sequential 8x8 shift-add squarer: one multiplier bit per cycle, LSB first.
// The operand is captured on start, so it doubles as the latch for operand a.
module evaluator_mul
    import evaluator_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [OP_W-1:0]     operand_i,
    output logic                done_o,
    output logic [2*OP_W-1:0]   product_o
);

    logic [2*OP_W-1:0] r_mcand;
    logic [OP_W-1:0]   r_mplier;
    logic [2*OP_W-1:0] r_acc;
    logic [2:0]        r_cnt;
    logic              r_busy;
    logic [2*OP_W-1:0] w_acc_next;

    // Accumulate step; product_o is the value after the current step so the
    // caller can capture it on the same edge that finishes the last bit.
    always_comb begin
        w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
        product_o  = w_acc_next;
        done_o     = r_busy && (r_cnt == 3'(MUL_ITERS - 1));
    end

    // Iteration registers; a new start overrides any step in flight.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (start_i) begin
            r_mcand  <= {{OP_W{1'b0}}, operand_i};
            r_mplier <= operand_i;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 3'd1;
            if (r_cnt == 3'(MUL_ITERS - 1)) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/evaluator_core.sv
// y = min(255, floor(sqrt(a^2 + b^2))) with a start/busy handshake.
// Squares come from one shared shift-add multiplier; the root is a restoring
// digit-by-digit square root, two radicand bits per cycle.
module evaluator_core
    import evaluator_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [OP_W-1:0] a_bi,
    input  logic [OP_W-1:0] b_bi,
    output logic            ready,
    output logic            busy_o,
    output logic [OP_W-1:0] y_bo
);

    state_e              r_state;
    state_e              w_next_state;
    logic                w_mul_start;
    logic [OP_W-1:0]     w_mul_op;
    logic                w_mul_done;
    logic [2*OP_W-1:0]   w_mul_prod;

    logic [OP_W-1:0]     r_b;
    logic [2*OP_W-1:0]   r_sq_a;
    logic [2*OP_W-1:0]   r_sq_b;
    logic [RAD_W-1:0]    r_rad;
    logic [11:0]         r_rem;
    logic [8:0]          r_root;
    logic [3:0]          r_cnt;
    logic [OP_W-1:0]     r_y;
    logic                r_ready;
    logic                r_busy;

    logic [11:0]         w_rem_shift;
    logic [11:0]         w_trial;
    logic                w_take;
    logic [11:0]         w_rem_next;
    logic [8:0]          w_root_next;
    logic                w_sqrt_last;

    evaluator_mul u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_mul_start),
        .operand_i (w_mul_op),
        .done_o    (w_mul_done),
        .product_o (w_mul_prod)
    );

    // One restoring sqrt step: bring down two radicand bits, try 4*root+1.
    always_comb begin
        w_rem_shift = {r_rem[9:0], r_rad[RAD_W-1 -: 2]};
        w_trial     = {1'b0, r_root, 2'b01};
        w_take      = (w_rem_shift >= w_trial);
        w_rem_next  = w_take ? (w_rem_shift - w_trial) : w_rem_shift;
        w_root_next = {r_root[7:0], w_take};
        w_sqrt_last = (r_cnt == 4'(SQRT_ITERS - 1));
    end

    // Next state and multiplier sequencing; b^2 starts on the edge a^2 ends.
    always_comb begin
        w_next_state = r_state;
        w_mul_start  = 1'b0;
        w_mul_op     = r_b;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_mul_start  = 1'b1;
                    w_mul_op     = a_bi;
                    w_next_state = MUL_A;
                end
            end
            MUL_A: begin
                if (w_mul_done) begin
                    w_mul_start  = 1'b1;
                    w_next_state = MUL_B;
                end
            end
            MUL_B: begin
                if (w_mul_done) begin
                    w_next_state = SUM;
                end
            end
            SUM:     w_next_state = SQRT;
            SQRT: begin
                if (w_sqrt_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_b     <= '0;
            r_sq_a  <= '0;
            r_sq_b  <= '0;
            r_rad   <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= '0;
            r_y     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_b     <= b_bi;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                MUL_A: begin
                    if (w_mul_done) begin
                        r_sq_a <= w_mul_prod;
                    end
                end
                MUL_B: begin
                    if (w_mul_done) begin
                        r_sq_b <= w_mul_prod;
                    end
                end
                SUM: begin
                    r_rad  <= RAD_W'(r_sq_a) + RAD_W'(r_sq_b);
                    r_rem  <= '0;
                    r_root <= '0;
                    r_cnt  <= '0;
                end
                SQRT: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_cnt  <= r_cnt + 4'd1;
                    if (w_sqrt_last) begin
                        r_y     <= w_root_next[8] ? 8'hFF : w_root_next[7:0];
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready  = r_ready;
    assign busy_o = r_busy;
    assign y_bo   = r_y;

endmodule

// File: tb/tb_evaluator_core.sv
// Self-checking bench for evaluator_core: directed table, random vectors
// against a plain-arithmetic model, and handshake/reset sequences.
module tb_evaluator_core;

    logic       clk_i;
    logic       rst_i;
    logic       start_i;
    logic [7:0] a_bi;
    logic [7:0] b_bi;
    logic       ready;
    logic       busy_o;
    logic [7:0] y_bo;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec_t;

    vec_t vecs [16];

    evaluator_core dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .a_bi    (a_bi),
        .b_bi    (b_bi),
        .ready   (ready),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= a*a + b*b, clipped to 255.
    function automatic int ref_y(input int a, input int b);
        int s;
        int r;
        s = a * a + b * b;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return (r > 255) ? 255 : r;
    endfunction

    // One full handshake; optionally disturb operands/start mid-computation.
    task automatic do_op(input string name, input int a, input int b, input int exp,
                         input bit disturb);
        int n;
        @(negedge clk_i);
        a_bi    = 8'(a);
        b_bi    = 8'(b);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check({name, ".busy_at_accept"}, int'(busy_o), 1);
        check({name, ".ready_at_accept"}, int'(ready), 0);
        n = 0;
        while (busy_o && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
            if (disturb) begin
                if (n == 3 || n == 12 || n == 20) begin
                    a_bi    = ~a_bi;
                    b_bi    = b_bi + 8'd37;
                    start_i = 1'b1;
                end else begin
                    start_i = 1'b0;
                end
            end
        end
        start_i = 1'b0;
        check({name, ".latency"}, n, 26);
        check({name, ".y"}, int'(y_bo), exp);
        check({name, ".ready"}, int'(ready), 1);
    endtask

    initial begin
        int n;
        int e;
        int a;
        int b;
        bit bad;

        vecs[0]  = '{8'd3,   8'd4,   8'd5};
        vecs[1]  = '{8'd5,   8'd12,  8'd13};
        vecs[2]  = '{8'd8,   8'd15,  8'd17};
        vecs[3]  = '{8'd1,   8'd1,   8'd1};
        vecs[4]  = '{8'd2,   8'd2,   8'd2};
        vecs[5]  = '{8'd1,   8'd5,   8'd5};
        vecs[6]  = '{8'd10,  8'd20,  8'd22};
        vecs[7]  = '{8'd15,  8'd6,   8'd16};
        vecs[8]  = '{8'd55,  8'd55,  8'd77};
        vecs[9]  = '{8'd8,   8'd9,   8'd12};
        vecs[10] = '{8'd0,   8'd0,   8'd0};
        vecs[11] = '{8'd200, 8'd0,   8'd200};
        vecs[12] = '{8'd0,   8'd255, 8'd255};
        vecs[13] = '{8'd180, 8'd180, 8'd254};
        vecs[14] = '{8'd181, 8'd181, 8'd255};
        vecs[15] = '{8'd255, 8'd255, 8'd255};

        // Reset held two cycles with start asserted: start must be ignored.
        rst_i   = 1'b0;
        start_i = 1'b1;
        a_bi    = 8'd3;
        b_bi    = 8'd4;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset.ready", int'(ready), 0);
        check("reset.busy", int'(busy_o), 0);
        check("reset.y", int'(y_bo), 0);
        @(negedge clk_i);
        rst_i   = 1'b1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("post_reset.busy", int'(busy_o), 0);
        check("post_reset.ready", int'(ready), 0);

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("vec%0d", i), int'(vecs[i].a), int'(vecs[i].b),
                  int'(vecs[i].y), 1'b0);
        end

        // Random vectors against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = (i % 4 == 0) ? int'($urandom_range(170, 255)) : int'($urandom_range(0, 255));
            b = (i % 4 == 0) ? int'($urandom_range(170, 255)) : int'($urandom_range(0, 255));
            do_op($sformatf("rnd%0d_%0d_%0d", i, a, b), a, b, ref_y(a, b), 1'b0);
        end

        // Operand changes and start pulses while busy are ignored.
        do_op("disturb", 20, 21, 29, 1'b1);
        do_op("disturb2", 7, 24, 25, 1'b1);

        // Start held high across completion: re-accepted on the following edge.
        @(negedge clk_i);
        a_bi    = 8'd6;
        b_bi    = 8'd8;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        n = 0;
        while (busy_o && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("b2b.first_latency", n, 26);
        check("b2b.first_y", int'(y_bo), 10);
        a_bi = 8'd9;
        b_bi = 8'd12;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("b2b.reaccept_busy", int'(busy_o), 1);
        check("b2b.reaccept_ready", int'(ready), 0);
        check("b2b.y_held", int'(y_bo), 10);
        n = 0;
        while (busy_o && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("b2b.second_latency", n, 26);
        check("b2b.second_y", int'(y_bo), 15);

        // Reset ten cycles into a computation aborts it with no later write.
        @(negedge clk_i);
        a_bi    = 8'd100;
        b_bi    = 8'd100;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("abort.y", int'(y_bo), 0);
        check("abort.ready", int'(ready), 0);
        check("abort.busy", int'(busy_o), 0);
        rst_i = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i);
            #1;
            if (busy_o || ready || y_bo != 8'd0) bad = 1'b1;
        end
        check("abort.no_late_write", int'(bad), 0);

        // Unit still works after the abort.
        e = ref_y(100, 100);
        do_op("after_abort", 100, 100, e, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
